// File: rtl/mips_io_bus_if.sv
// -----------------------------------------------------------------------------
// mips_io_bus_if
// CPU-side memory bus between mipscpu and mips_io_bus.
//   adr        CPU address
//   writedata  CPU write data
//   memwrite   CPU write strobe
//   memdata    read data returned to the CPU (1-cycle latency)
// master: the CPU (or a bench driving it); slave: mips_io_bus.
// -----------------------------------------------------------------------------
interface mips_io_bus_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] writedata;
    logic              memwrite;
    logic [DATA_W-1:0] memdata;

    modport master (
        output adr,
        output writedata,
        output memwrite,
        input  memdata
    );

    modport slave (
        input  adr,
        input  writedata,
        input  memwrite,
        output memdata
    );
endinterface

// File: rtl/mips_io_bus.sv
// -----------------------------------------------------------------------------
// mips_io_bus
// Memory/IO bus between mipscpu and exmem. Addresses IO_BASE..IO_BASE+3 form an
// IO window (LED register, debounced switches, switch rising-edge capture,
// free-running timer); everything below goes straight to exmem.
//   clk, rst   system clock, synchronous active-high reset
//   cpu        CPU bus (adr, writedata, memwrite in; memdata out)
//   mem_addr   exmem address      (= adr)
//   mem_data   exmem write data   (= writedata)
//   mem_wen    exmem write enable (memwrite outside the IO window)
//   mem_q      exmem read data, valid 1 cycle after mem_addr
//   switches   raw board switches, asynchronous to clk
//   leds       LED register
// IO map (offset from IO_BASE):
//   0 RW leds | 1 RO debounced switches | 2 W1C rising-edge capture | 3 timer (write clears)
// -----------------------------------------------------------------------------
module mips_io_bus #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int IO_BASE   = 2**ADDR_W - 4,
    parameter int DB_CYCLES = 1000,
    parameter int TIMER_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    mips_io_bus_if.slave        cpu,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic                mem_wen,
    input  logic [DATA_W-1:0]   mem_q,
    input  logic [DATA_W-1:0]   switches,
    output logic [DATA_W-1:0]   leds
);

    localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
    localparam int                DB_W      = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam int                PRE_W     = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TIMER_DIV - 1);

    logic              io_hit;
    logic [1:0]        off;
    logic              wr_io;
    logic              db_update;
    logic [DATA_W-1:0] edge_clr;
    logic [DATA_W-1:0] io_rd;

    logic [DATA_W-1:0] leds_q,   leds_d;
    logic [DATA_W-1:0] sw_s1_q,  sw_s1_d;
    logic [DATA_W-1:0] sw_s2_q,  sw_s2_d;
    logic [DATA_W-1:0] sw_deb_q, sw_deb_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [DATA_W-1:0] edge_q,   edge_d;
    logic [PRE_W-1:0]  pre_q,    pre_d;
    logic [DATA_W-1:0] timer_q,  timer_d;
    logic              sel_q,    sel_d;
    logic [DATA_W-1:0] io_q,     io_d;

    // Only the low two bits of (adr - IO_BASE) are needed, and those depend
    // only on the low two bits of each operand.
    assign io_hit = (cpu.adr >= IO_BASE_A);
    assign off    = cpu.adr[1:0] - IO_BASE_A[1:0];
    assign wr_io  = cpu.memwrite & io_hit;

    assign mem_addr    = cpu.adr;
    assign mem_data    = cpu.writedata;
    assign mem_wen     = cpu.memwrite & ~io_hit;
    assign cpu.memdata = sel_q ? io_q : mem_q;
    assign leds        = leds_q;

    always_comb begin
        leds_d    = leds_q;
        sw_s1_d   = switches;
        sw_s2_d   = sw_s1_q;
        sw_deb_d  = sw_deb_q;
        db_cnt_d  = '0;
        db_update = 1'b0;
        edge_clr  = '0;
        pre_d     = pre_q;
        timer_d   = timer_q;
        io_rd     = '0;

        if (wr_io && off == 2'd0) begin
            leds_d = cpu.writedata;
        end

        // Whole-vector debounce: any return to the accepted value restarts the count.
        if (sw_s2_q != sw_deb_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_update = 1'b1;
                sw_deb_d  = sw_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Clear is applied first so a rising edge accepted in the same cycle survives.
        if (wr_io && off == 2'd2) begin
            edge_clr = cpu.writedata;
        end
        edge_d = edge_q & ~edge_clr;
        if (db_update) begin
            edge_d = edge_d | (sw_s2_q & ~sw_deb_q);
        end

        if (wr_io && off == 2'd3) begin
            pre_d   = '0;
            timer_d = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d   = '0;
            timer_d = timer_q + 1'b1;
        end else begin
            pre_d   = pre_q + 1'b1;
        end

        case (off)
            2'd0:    io_rd = leds_q;
            2'd1:    io_rd = sw_deb_q;
            2'd2:    io_rd = edge_q;
            default: io_rd = timer_q;
        endcase

        // io_q takes the pre-write register value on a same-cycle write/read.
        sel_d = io_hit;
        io_d  = io_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q   <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            sw_deb_q <= '0;
            db_cnt_q <= '0;
            edge_q   <= '0;
            pre_q    <= '0;
            timer_q  <= '0;
            sel_q    <= 1'b0;
            io_q     <= '0;
        end else begin
            leds_q   <= leds_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            sw_deb_q <= sw_deb_d;
            db_cnt_q <= db_cnt_d;
            edge_q   <= edge_d;
            pre_q    <= pre_d;
            timer_q  <= timer_d;
            sel_q    <= sel_d;
            io_q     <= io_d;
        end
    end

endmodule

// File: tb/tb_mips_io_bus.sv
// -----------------------------------------------------------------------------
// tb_mips_io_bus
// Directed bench for mips_io_bus with DB_CYCLES=4, TIMER_DIV=2. A small exmem
// model sits on the memory side. Expected read data is queued when a read is
// issued and compared when memdata is valid one cycle later.
// -----------------------------------------------------------------------------
module tb_mips_io_bus;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_wen;
    logic [7:0] mem_q;
    logic [7:0] switches;
    logic [7:0] leds;

    mips_io_bus_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    mips_io_bus #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .DB_CYCLES (4),
        .TIMER_DIV (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu      (bus),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wen  (mem_wen),
        .mem_q    (mem_q),
        .switches (switches),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    // exmem model: unwritten locations read back as (addr ^ 0x5A).
    bit [7:0] tb_mem [256];

    always @(posedge clk) begin
        if (mem_wen) tb_mem[mem_addr] <= mem_data ^ mem_addr ^ 8'h5A;
        mem_q <= tb_mem[mem_addr] ^ mem_addr ^ 8'h5A;
    end

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] sb [$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected queued value", tag);
        end else begin
            e = sb.pop_front();
            check(tag, bus.memdata, e);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.adr      = a;
        bus.memwrite = 1'b0;
        sb.push_back(exp);
        tick();
        pop_chk(tag);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.adr       = a;
        bus.writedata = d;
        bus.memwrite  = 1'b1;
        #1;
        check("mem_wen", {7'b0, mem_wen}, (a < 8'hFC) ? 8'h01 : 8'h00);
        tick();
        bus.memwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.adr       = 8'h00;
        bus.writedata = 8'h00;
        bus.memwrite  = 1'b0;
        switches      = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_leds", leds, 8'h00);
        check("rst_memdata", bus.memdata, 8'h5A);
        rd("rst_deb", 8'hFD, 8'h00);
        rd("rst_edge", 8'hFE, 8'h00);

        // LED register write/read, same-cycle write and read
        wr(8'hFC, 8'hA5);
        check("t1_leds", leds, 8'hA5);
        rd("t1_rd", 8'hFC, 8'hA5);
        sb.push_back(8'hA5);
        wr(8'hFC, 8'h5A);
        pop_chk("t1_rw_same");
        check("t1_leds2", leds, 8'h5A);

        // exmem path
        wr(8'h10, 8'h3C);
        check("t2_leds", leds, 8'h5A);
        rd("t2_rd", 8'h10, 8'h3C);
        check("t2_mem_addr", mem_addr, 8'h10);
        rd("t2_rd_unwritten", 8'h11, 8'h4B);
        wr(8'hFD, 8'hFF);
        rd("ro_ignore", 8'hFD, 8'h00);

        // debounce latency: sw_deb changes exactly DB_CYCLES+2 edges after the switch change
        bus.adr      = 8'hFD;
        bus.memwrite = 1'b0;
        switches     = 8'h81;
        for (int k = 1; k <= 7; k++) begin
            sb.push_back((k == 7) ? 8'h81 : 8'h00);
            tick();
            pop_chk("t3_latency");
        end
        rd("t3_edge", 8'hFE, 8'h81);

        // 3-cycle glitch is rejected
        bus.adr  = 8'hFD;
        switches = 8'h80;
        repeat (3) tick();
        switches = 8'h81;
        for (int k = 0; k < 8; k++) rd("t3_bounce", 8'hFD, 8'h81);

        // W1C clear, falling edges do not set, set wins over same-cycle clear
        wr(8'hFE, 8'h01);
        rd("t4_clr", 8'hFE, 8'h80);
        bus.adr  = 8'hFD;
        switches = 8'h80;
        repeat (7) tick();
        rd("t4_fall_deb", 8'hFD, 8'h80);
        rd("t4_fall_edge", 8'hFE, 8'h80);
        bus.adr  = 8'hFD;
        switches = 8'h81;
        repeat (5) tick();
        wr(8'hFE, 8'h01);
        rd("t4_set_wins", 8'hFE, 8'h81);
        rd("t4_deb", 8'hFD, 8'h81);

        // timer: one increment every 2 cycles, wraps 0xFF -> 0x00
        wr(8'hFF, 8'h55);
        for (int k = 1; k <= 520; k++) begin
            bus.adr = 8'hFF;
            sb.push_back(8'((k - 1) / 2));
            tick();
            pop_chk("t5_timer");
        end
        sb.push_back(8'h04);
        tick();
        pop_chk("t5_timer");
        wr(8'hFF, 8'hAA);
        for (int k = 1; k <= 6; k++) begin
            bus.adr = 8'hFF;
            sb.push_back(8'((k - 1) / 2));
            tick();
            pop_chk("t5_clear");
        end

        // reset mid-debounce
        wr(8'hFC, 8'hFF);
        check("t6_leds_pre", leds, 8'hFF);
        rd("t6_edge_pre", 8'hFE, 8'h81);
        bus.adr  = 8'hFE;
        switches = 8'h01;
        repeat (3) tick();
        rst           = 1'b1;
        bus.adr       = 8'h20;
        bus.writedata = 8'h77;
        bus.memwrite  = 1'b1;
        #1;
        check("t6_wen_rst", {7'b0, mem_wen}, 8'h01);
        tick();
        rst          = 1'b0;
        bus.memwrite = 1'b0;
        check("t6_leds", leds, 8'h00);
        check("t6_memdata", bus.memdata, 8'h7A);
        bus.adr = 8'hFD;
        for (int k = 1; k <= 7; k++) begin
            sb.push_back((k == 7) ? 8'h01 : 8'h00);
            tick();
            pop_chk("t6_restart");
        end
        rd("t6_edge", 8'hFE, 8'h01);
        rd("t6_exmem", 8'h20, 8'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
